synaptic_row_streamer: RTL

- Parametrised successor to the fixed 4-bit time-multiplexed synaptic array.
- On a presynaptic event, it scans that neuron's full synaptic row from a single-port SRAM and streams one weight per postsynaptic neuron to the neuron core over a valid/ready handshake.
- Weight width and neuron count are generic.
- An OBI slave port gives the host byte-masked read/write access to the array whenever the scan engine does not own the SRAM.

---
 rtl/synaptic_pkg.sv | 45 ++++
 rtl/sram_be_wrapper.sv | 34 +++
 rtl/synaptic_row_streamer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/synaptic_pkg.sv
// Shared types, derived-size helpers and the FSM state encoding for the synaptic row streamer.
package synaptic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      EMIT
   } state_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_rsp_t;

   function automatic int calc_wpw(input int wbits);
      return 32 / wbits;
   endfunction

   function automatic int calc_wpr(input int n, input int wbits);
      return (n * wbits) / 32;
   endfunction

   function automatic int calc_depth(input int n, input int wbits);
      return n * calc_wpr(n, wbits);
   endfunction

   function automatic int calc_aw(input int n, input int wbits);
      return $clog2(calc_depth(n, wbits));
   endfunction

   function automatic bit wbits_ok(input int wbits);
      return (wbits == 1) || (wbits == 2) || (wbits == 4) || (wbits == 8);
   endfunction

endpackage

// File: rtl/sram_be_wrapper.sv
// Behavioural single-port SRAM with byte enables and a registered read port.
// Replace the body of this module to map onto a foundry macro or FPGA block RAM.
module sram_be_wrapper #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               cs,
   input  logic               we,
   input  logic [WIDTH/8-1:0] be,
   input  logic [AW-1:0]      addr,
   input  logic [WIDTH-1:0]   wdata,
   output logic [WIDTH-1:0]   q
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Writes leave q untouched; only reads refresh the output register.
   always_ff @(posedge clk) begin
      if (cs) begin
         if (we) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
               if (be[b]) begin
                  mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end else begin
            q <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/synaptic_row_streamer.sv
// Streams one presynaptic neuron's weight row from SRAM to the neuron core; OBI host port shares the SRAM.
// Build option: define SYN_ZERO_SKIP_EN to suppress zero-weight beats.
module synaptic_row_streamer
   import synaptic_pkg::*;
#(
   parameter int  N     = 256,
   parameter int  M     = 8,
   parameter int  WBITS = 4,
   parameter type req_t = obi_req_t,
   parameter type rsp_t = obi_rsp_t
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             event_valid_i,
   input  logic [M-1:0]     event_idx_i,
   output logic             event_ready_o,
   output logic             weight_valid_o,
   input  logic             weight_ready_i,
   output logic [WBITS-1:0] weight_o,
   output logic [M-1:0]     post_idx_o,
   output logic             row_done_o,
   output logic             busy_o,
   input  req_t             obi_req_i,
   output rsp_t             obi_rsp_o
);

   localparam int WPW   = calc_wpw(WBITS);
   localparam int WPR   = calc_wpr(N, WBITS);
   localparam int DEPTH = calc_depth(N, WBITS);
   localparam int AW    = calc_aw(N, WBITS);
   localparam int LW    = (WPW > 1) ? $clog2(WPW) : 1;
   localparam int CW    = (WPR > 1) ? $clog2(WPR) : 1;

   if (!wbits_ok(WBITS)) begin : g_bad_wbits
      $error("WBITS must be 1, 2, 4 or 8");
   end
   if ((N * WBITS) % 32 != 0) begin : g_bad_row
      $error("N*WBITS must be a multiple of 32");
   end
   if (M != $clog2(N)) begin : g_bad_m
      $error("M must equal clog2(N)");
   end

   state_t           state, next_state;
   logic [M-1:0]     pre_idx;
   logic [CW-1:0]    word_cnt;
   logic [LW-1:0]    lane;
   logic [31:0]      buffer;
   logic             accept, advance, last_lane, last_word;
   logic [WBITS-1:0] lane_weight;
   logic [AW-1:0]    scan_addr;
   logic             gnt, rvalid_q, rd_is_read;
   logic             mem_cs, mem_we;
   logic [3:0]       mem_be;
   logic [AW-1:0]    mem_addr;
   logic [31:0]      mem_wdata, mem_q;
   logic             unused_addr_bits;

   assign lane_weight = buffer[int'(lane)*WBITS +: WBITS];
   assign last_lane   = (int'(lane) == WPW - 1);
   assign last_word   = (int'(word_cnt) == WPR - 1);
   assign scan_addr   = AW'(int'(pre_idx) * WPR + int'(word_cnt));
   assign busy_o      = (state != IDLE);
   assign weight_o    = (state == EMIT) ? lane_weight : '0;
   assign post_idx_o  = (state == EMIT) ? M'(int'(word_cnt) * WPW + int'(lane)) : '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state     = state;
      event_ready_o  = 1'b0;
      weight_valid_o = 1'b0;
      row_done_o     = 1'b0;
      accept         = 1'b0;
      advance        = 1'b0;
      case (state)
         IDLE: begin
            event_ready_o = 1'b1;
            if (event_valid_i) begin
               accept     = 1'b1;
               next_state = FETCH;
            end
         end
         FETCH: next_state = WAIT;
         WAIT:  next_state = EMIT;
         EMIT: begin
`ifdef SYN_ZERO_SKIP_EN
            // Zero lanes are never shown to the core and step on unconditionally.
            weight_valid_o = (lane_weight != '0);
            advance        = !weight_valid_o || weight_ready_i;
`else
            weight_valid_o = 1'b1;
            advance        = weight_ready_i;
`endif
            if (advance && last_lane) begin
               if (last_word) begin
                  row_done_o = 1'b1;
                  next_state = IDLE;
               end else begin
                  next_state = FETCH;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pre_idx  <= '0;
         word_cnt <= '0;
         lane     <= '0;
         buffer   <= '0;
      end else begin
         if (accept) begin
            pre_idx  <= event_idx_i;
            word_cnt <= '0;
            lane     <= '0;
         end
         if (state == WAIT) begin
            buffer <= mem_q;
         end
         if (advance) begin
            if (!last_lane) begin
               lane <= lane + LW'(1);
            end else begin
               lane <= '0;
               if (!last_word) begin
                  word_cnt <= word_cnt + CW'(1);
               end
            end
         end
      end
   end

   // The scan engine only needs the port during FETCH; the host gets it every other cycle.
   assign gnt = obi_req_i.req && (state != FETCH);

   always_comb begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = scan_addr;
      mem_wdata = obi_req_i.wdata;
      if (state == FETCH) begin
         mem_cs = 1'b1;
      end else if (obi_req_i.req) begin
         mem_cs   = 1'b1;
         mem_we   = obi_req_i.we;
         mem_be   = obi_req_i.be;
         mem_addr = obi_req_i.addr[AW+1:2];
      end
   end

   assign unused_addr_bits = ^{obi_req_i.addr[31:AW+2], obi_req_i.addr[1:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         rvalid_q   <= 1'b0;
         rd_is_read <= 1'b0;
      end else begin
         rvalid_q   <= gnt;
         rd_is_read <= gnt && !obi_req_i.we;
      end
   end

   always_comb begin
      obi_rsp_o        = '0;
      obi_rsp_o.gnt    = gnt;
      obi_rsp_o.rvalid = rvalid_q;
      obi_rsp_o.rdata  = (rvalid_q && rd_is_read) ? mem_q : 32'h0;
   end

   sram_be_wrapper #(
      .DEPTH(DEPTH),
      .WIDTH(32)
   ) u_sram (
      .clk  (CLK),
      .cs   (mem_cs),
      .we   (mem_we),
      .be   (mem_be),
      .addr (mem_addr),
      .wdata(mem_wdata),
      .q    (mem_q)
   );

endmodule
